pcie_trn_tx_arbiter: RTL and testbench

//  Shares the Virtex-6 PCIe core TRN transmit interface (trn_t*) between N TLP sources (completer, DMA write, DMA read-request).

---
 rtl/pcie_trn_tx_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_pcie_trn_tx_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_trn_tx_arbiter.sv
// Round-robin arbiter sharing the Virtex-6 PCIe TRN transmit port between
// N_REQ TLP sources. Grants are held for a whole TLP. New TLPs start only
// with link up and enough transmit buffers. A stalled owner is discontinued.
module pcie_trn_tx_arbiter #(
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned TBUF_MIN    = 2,
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic                  trn_clk,
    input  logic                  trn_reset_n,
    input  logic                  trn_lnk_up_n,
    input  logic [5:0]            trn_tbuf_av,
    input  logic [N_REQ-1:0]      req_tsof_n,
    input  logic [N_REQ-1:0]      req_teof_n,
    input  logic [64*N_REQ-1:0]   req_td,
    input  logic [N_REQ-1:0]      req_trem_n,
    input  logic [N_REQ-1:0]      req_tsrc_rdy_n,
    output logic [N_REQ-1:0]      req_tdst_rdy_n,
    output logic [N_REQ-1:0]      req_tdsc,
    output logic                  trn_tsof_n,
    output logic                  trn_teof_n,
    output logic [63:0]           trn_td,
    output logic                  trn_trem_n,
    output logic                  trn_tsrc_rdy_n,
    input  logic                  trn_tdst_rdy_n,
    output logic                  trn_tsrc_dsc_n,
    output logic [N_REQ-1:0]      grant,
    output logic                  proto_err
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TBUF_W = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DSC  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [IDX_W-1:0] last_grant, last_grant_nxt;
    logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;
    logic             proto_err_nxt;
    logic             first_beat, first_beat_nxt;

    logic [N_REQ-1:0]  cand;
    logic [N_REQ-1:0]  non_sof;
    logic              found;
    logic [IDX_W-1:0]  win;
    logic              own_sof_n, own_eof_n, own_rem_n, own_rdy_n;
    logic [DATA_W-1:0] own_td;
    logic              beat;

    assign cand    = ~req_tsrc_rdy_n & ~req_tsof_n;
    assign non_sof = ~req_tsrc_rdy_n &  req_tsof_n;
    assign beat    = ~own_rdy_n & ~trn_tdst_rdy_n;

    // Select the current owner's TRN signals (owner index is last_grant).
    always_comb begin
        own_sof_n = 1'b1;
        own_eof_n = 1'b1;
        own_rem_n = 1'b1;
        own_rdy_n = 1'b1;
        own_td    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (last_grant == IDX_W'(i)) begin
                own_sof_n = req_tsof_n[i];
                own_eof_n = req_teof_n[i];
                own_rem_n = req_trem_n[i];
                own_rdy_n = req_tsrc_rdy_n[i];
                own_td    = req_td[DATA_W*i +: DATA_W];
            end
        end
    end

    // Round-robin search starting just after the previous winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            int unsigned idx;
            idx = (32'(last_grant) + k) % N_REQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    // State register and arbitration bookkeeping.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state      <= S_IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
            stall_cnt  <= '0;
            proto_err  <= 1'b0;
            first_beat <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            stall_cnt  <= stall_cnt_nxt;
            proto_err  <= proto_err_nxt;
            first_beat <= first_beat_nxt;
        end
    end

    // Next-state logic: TLP start, end, link loss and stall discontinue.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        stall_cnt_nxt  = stall_cnt;
        proto_err_nxt  = proto_err;
        first_beat_nxt = first_beat;
        case (state)
            S_IDLE: begin
                if (|non_sof) begin
                    proto_err_nxt = 1'b1;
                end
                if (!trn_lnk_up_n && (trn_tbuf_av >= TBUF_W'(TBUF_MIN)) && found) begin
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        grant_nxt[i] = (win == IDX_W'(i));
                    end
                    last_grant_nxt = win;
                    stall_cnt_nxt  = '0;
                    first_beat_nxt = 1'b1;
                    state_nxt      = S_XFER;
                end
            end
            S_XFER: begin
                if (trn_lnk_up_n) begin
                    state_nxt     = S_IDLE;
                    grant_nxt     = '0;
                    stall_cnt_nxt = '0;
                end else if (!own_rdy_n) begin
                    stall_cnt_nxt = '0;
                    if (beat) begin
                        first_beat_nxt = 1'b0;
                        if (!first_beat && !own_sof_n) begin
                            proto_err_nxt = 1'b1;
                        end
                        if (!own_eof_n) begin
                            state_nxt = S_IDLE;
                            grant_nxt = '0;
                        end
                    end
                end else if (stall_cnt == CNT_W'(STALL_LIMIT - 1)) begin
                    stall_cnt_nxt = '0;
                    state_nxt     = S_DSC;
                end else begin
                    stall_cnt_nxt = stall_cnt + CNT_W'(1);
                end
            end
            S_DSC: begin
                proto_err_nxt = 1'b1;
                grant_nxt     = '0;
                state_nxt     = S_IDLE;
            end
            default: begin
                grant_nxt = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Data path: owner's signals muxed straight through to the core.
    always_comb begin
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_td         = '0;
        trn_trem_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        trn_tsrc_dsc_n = 1'b1;
        req_tdst_rdy_n = '1;
        req_tdsc       = '0;
        if (state == S_XFER) begin
            trn_tsof_n     = own_sof_n;
            trn_teof_n     = own_eof_n;
            trn_td         = own_td;
            trn_trem_n     = own_rem_n;
            trn_tsrc_rdy_n = own_rdy_n;
        end
        if (state == S_DSC) begin
            trn_tsrc_dsc_n = 1'b0;
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (last_grant == IDX_W'(i)) begin
                if (state == S_XFER) begin
                    req_tdst_rdy_n[i] = trn_tdst_rdy_n;
                end
                if (state == S_DSC) begin
                    req_tdsc[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcie_trn_tx_arbiter.sv
// Directed bench for pcie_trn_tx_arbiter with a behavioural reference model.
module tb_pcie_trn_tx_arbiter;

    localparam int N     = 3;
    localparam int STALL = 255;

    logic            trn_clk = 1'b0;
    logic            trn_reset_n;
    logic            trn_lnk_up_n;
    logic [5:0]      trn_tbuf_av;
    logic [N-1:0]    req_tsof_n, req_teof_n, req_trem_n, req_tsrc_rdy_n;
    logic [64*N-1:0] req_td;
    logic [N-1:0]    req_tdst_rdy_n, req_tdsc, grant;
    logic            trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n;
    logic [63:0]     trn_td;
    logic            trn_tdst_rdy_n, trn_tsrc_dsc_n, proto_err;

    pcie_trn_tx_arbiter #(.N_REQ(N), .TBUF_MIN(2), .STALL_LIMIT(STALL)) dut (
        .trn_clk(trn_clk), .trn_reset_n(trn_reset_n), .trn_lnk_up_n(trn_lnk_up_n),
        .trn_tbuf_av(trn_tbuf_av), .req_tsof_n(req_tsof_n), .req_teof_n(req_teof_n),
        .req_td(req_td), .req_trem_n(req_trem_n), .req_tsrc_rdy_n(req_tsrc_rdy_n),
        .req_tdst_rdy_n(req_tdst_rdy_n), .req_tdsc(req_tdsc), .trn_tsof_n(trn_tsof_n),
        .trn_teof_n(trn_teof_n), .trn_td(trn_td), .trn_trem_n(trn_trem_n),
        .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
        .trn_tsrc_dsc_n(trn_tsrc_dsc_n), .grant(grant), .proto_err(proto_err)
    );

    always #5 trn_clk = ~trn_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_owner = -1;   // -1 when no TLP owns the port
    int m_last  = N-1;
    int m_run   = 0;    // consecutive owner-idle cycles
    bit m_dsc   = 1'b0;
    bit m_first = 1'b0;
    bit m_perr  = 1'b0;

    function automatic int rr_pick(input int last, input logic [N-1:0] c);
        int j;
        for (int k = 1; k <= N; k++) begin
            j = (last + k) % N;
            if (c[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            m_owner <= -1; m_last <= N-1; m_run <= 0;
            m_dsc <= 1'b0; m_first <= 1'b0; m_perr <= 1'b0;
        end else if (m_dsc) begin
            m_perr <= 1'b1; m_dsc <= 1'b0; m_owner <= -1;
        end else if (m_owner < 0) begin
            if (|(~req_tsrc_rdy_n & req_tsof_n)) m_perr <= 1'b1;
            if (!trn_lnk_up_n && trn_tbuf_av >= 6'd2 &&
                rr_pick(m_last, ~req_tsrc_rdy_n & ~req_tsof_n) >= 0) begin
                m_owner <= rr_pick(m_last, ~req_tsrc_rdy_n & ~req_tsof_n);
                m_last  <= rr_pick(m_last, ~req_tsrc_rdy_n & ~req_tsof_n);
                m_first <= 1'b1;
                m_run   <= 0;
            end
        end else if (trn_lnk_up_n) begin
            m_owner <= -1; m_run <= 0;
        end else if (!req_tsrc_rdy_n[m_owner]) begin
            m_run <= 0;
            if (!trn_tdst_rdy_n) begin
                m_first <= 1'b0;
                if (!m_first && !req_tsof_n[m_owner]) m_perr <= 1'b1;
                if (!req_teof_n[m_owner]) m_owner <= -1;
            end
        end else if (m_run + 1 >= STALL) begin
            m_dsc <= 1'b1; m_run <= 0;
        end else begin
            m_run <= m_run + 1;
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    initial begin
        logic [N-1:0] e_grant, e_dst, e_tdsc;
        logic [63:0]  e_td;
        logic         e_sof, e_eof, e_rem, e_rdy, e_dsc;
        forever begin
            @(negedge trn_clk);
            e_grant = '0; e_dst = '1; e_tdsc = '0; e_td = '0;
            e_sof = 1'b1; e_eof = 1'b1; e_rem = 1'b1; e_rdy = 1'b1; e_dsc = 1'b1;
            if (m_owner >= 0) begin
                e_grant[m_owner] = 1'b1;
                if (m_dsc) begin
                    e_dsc = 1'b0;
                    e_tdsc[m_owner] = 1'b1;
                end else begin
                    e_sof = req_tsof_n[m_owner];
                    e_eof = req_teof_n[m_owner];
                    e_rem = req_trem_n[m_owner];
                    e_rdy = req_tsrc_rdy_n[m_owner];
                    e_td  = req_td[64*m_owner +: 64];
                    e_dst[m_owner] = trn_tdst_rdy_n;
                end
            end
            chk("grant", 64'(grant), 64'(e_grant));
            chk("proto_err", 64'(proto_err), 64'(m_perr));
            chk("trn_tsof_n", 64'(trn_tsof_n), 64'(e_sof));
            chk("trn_teof_n", 64'(trn_teof_n), 64'(e_eof));
            chk("trn_trem_n", 64'(trn_trem_n), 64'(e_rem));
            chk("trn_tsrc_rdy_n", 64'(trn_tsrc_rdy_n), 64'(e_rdy));
            chk("trn_td", trn_td, e_td);
            chk("trn_tsrc_dsc_n", 64'(trn_tsrc_dsc_n), 64'(e_dsc));
            chk("req_tdst_rdy_n", 64'(req_tdst_rdy_n), 64'(e_dst));
            chk("req_tdsc", 64'(req_tdsc), 64'(e_tdsc));
        end
    end

    // ---------------- requester stimulus ----------------
    int rem [N];   // TLPs still to send
    int len [N];   // beats per TLP
    int bidx[N];   // current beat index
    int seq [N];   // TLP sequence number
    bit ven [N];   // requester keeps src_rdy asserted
    int core_beats = 0;
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] gq[$];

    task automatic update_drive();
        for (int i = 0; i < N; i++) begin
            if (rem[i] > 0 && ven[i]) begin
                req_tsrc_rdy_n[i] = 1'b0;
                req_tsof_n[i]     = (bidx[i] == 0) ? 1'b0 : 1'b1;
                req_teof_n[i]     = (bidx[i] == len[i]-1) ? 1'b0 : 1'b1;
                req_trem_n[i]     = (bidx[i] == len[i]-1) ? 1'b1 : 1'b0;
                req_td[64*i +: 64] = {8'(8'hA0 + i), 24'(seq[i]), 32'(bidx[i])};
            end else begin
                req_tsrc_rdy_n[i] = 1'b1;
                req_tsof_n[i]     = 1'b1;
                req_teof_n[i]     = 1'b1;
                req_trem_n[i]     = 1'b1;
                req_td[64*i +: 64] = '0;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] acc;
        @(negedge trn_clk);
        acc = ~req_tdst_rdy_n & ~req_tsrc_rdy_n;
        if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) core_beats++;
        if (grant != '0 && prev_grant == '0) gq.push_back(grant);
        prev_grant = grant;
        @(posedge trn_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                bidx[i]++;
                if (bidx[i] >= len[i]) begin
                    bidx[i] = 0; rem[i]--; seq[i]++;
                end
            end
        end
        update_drive();
    endtask

    function automatic bit busy();
        bit b = (grant != '0);
        for (int i = 0; i < N; i++) if (rem[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input int budget);
        int c = 0;
        while (busy() && c < budget) begin
            step();
            c++;
        end
        chk("drain_done", 64'(busy()), 64'(0));
    endtask

    task automatic do_reset();
        trn_reset_n = 1'b0;
        trn_lnk_up_n = 1'b0; trn_tbuf_av = 6'd4; trn_tdst_rdy_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; len[i] = 1; bidx[i] = 0; seq[i] = 0; ven[i] = 1'b1;
        end
        update_drive();
        gq.delete();
        prev_grant = '0;
        repeat (2) @(posedge trn_clk);
        #3 trn_reset_n = 1'b1;
        @(posedge trn_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cb0;
        do_reset();
        chk("reset_grant", 64'(grant), 64'(0));
        chk("reset_src_rdy", 64'(trn_tsrc_rdy_n), 64'(1));
        chk("reset_dst_rdy", 64'(req_tdst_rdy_n), 64'(3'b111));
        chk("reset_td", trn_td, 64'h0);

        // single 3-beat TLP from requester 0
        rem[0] = 1; len[0] = 3; update_drive();
        cb0 = core_beats;
        step();
        chk("t1_grant", 64'(grant), 64'(3'b001));
        chk("t1_sof", 64'(trn_tsof_n), 64'(0));
        chk("t1_td", trn_td, 64'hA000_0000_0000_0000);
        repeat (3) step();
        chk("t1_grant_idle", 64'(grant), 64'(0));
        chk("t1_beats", 64'(core_beats - cb0), 64'(3));

        // round-robin across three always-ready requesters
        do_reset();
        for (int i = 0; i < N; i++) begin rem[i] = 2; len[i] = 1; end
        update_drive();
        drain(40);
        chk("rr_count", 64'(gq.size()), 64'(6));
        chk("rr_0", 64'(gq.size() > 0 ? gq[0] : 3'b0), 64'(3'b001));
        chk("rr_1", 64'(gq.size() > 1 ? gq[1] : 3'b0), 64'(3'b010));
        chk("rr_2", 64'(gq.size() > 2 ? gq[2] : 3'b0), 64'(3'b100));
        chk("rr_3", 64'(gq.size() > 3 ? gq[3] : 3'b0), 64'(3'b001));

        // buffer gating at TLP start only
        do_reset();
        trn_tbuf_av = 6'd1;
        rem[1] = 1; len[1] = 3; update_drive();
        for (int k = 0; k < 10; k++) begin
            step();
            chk("tbuf_hold", 64'(grant), 64'(0));
        end
        trn_tbuf_av = 6'd2;
        step();
        chk("tbuf_grant", 64'(grant), 64'(3'b010));
        trn_tbuf_av = 6'd0;
        drain(20);
        trn_tbuf_av = 6'd4;

        // owner stalls after SOF -> discontinue
        do_reset();
        rem[0] = 1; len[0] = 3; update_drive();
        step(); step();
        ven[0] = 1'b0; update_drive();
        repeat (STALL - 1) step();
        chk("stall_pre_dsc", 64'(trn_tsrc_dsc_n), 64'(1));
        step();
        chk("dsc_n", 64'(trn_tsrc_dsc_n), 64'(0));
        chk("dsc_tdsc", 64'(req_tdsc), 64'(3'b001));
        chk("dsc_src_rdy", 64'(trn_tsrc_rdy_n), 64'(1));
        rem[0] = 0; bidx[0] = 0; ven[0] = 1'b1; update_drive();
        step();
        chk("dsc_idle_grant", 64'(grant), 64'(0));
        chk("dsc_perr", 64'(proto_err), 64'(1));
        chk("dsc_pulse_end", 64'(req_tdsc), 64'(0));

        // core back-pressure mid-TLP does not count as a stall
        do_reset();
        rem[2] = 1; len[2] = 4; update_drive();
        cb0 = core_beats;
        step();
        chk("bp_grant", 64'(grant), 64'(3'b100));
        step(); step();
        trn_tdst_rdy_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            step();
            if (k % 50 == 0) chk("bp_td_hold", trn_td, 64'hA200_0000_0000_0002);
        end
        chk("bp_no_dsc", 64'(trn_tsrc_dsc_n), 64'(1));
        trn_tdst_rdy_n = 1'b0;
        drain(20);
        chk("bp_beats", 64'(core_beats - cb0), 64'(4));
        chk("bp_perr", 64'(proto_err), 64'(0));

        // link loss mid-TLP
        do_reset();
        rem[1] = 1; len[1] = 4; update_drive();
        step(); step();
        trn_lnk_up_n = 1'b1;
        rem[1] = 0; bidx[1] = 0; update_drive();
        step();
        chk("lnk_grant", 64'(grant), 64'(0));
        chk("lnk_src_rdy", 64'(trn_tsrc_rdy_n), 64'(1));
        chk("lnk_perr", 64'(proto_err), 64'(0));
        rem[0] = 1; len[0] = 1; update_drive();
        repeat (3) step();
        chk("lnk_down_nogrant", 64'(grant), 64'(0));
        trn_lnk_up_n = 1'b0;
        step();
        chk("lnk_up_grant", 64'(grant), 64'(3'b001));
        drain(20);

        // asynchronous reset mid-TLP
        do_reset();
        rem[0] = 1; len[0] = 4; update_drive();
        step(); step();
        #2 trn_reset_n = 1'b0;
        #1;
        chk("arst_grant", 64'(grant), 64'(0));
        chk("arst_src_rdy", 64'(trn_tsrc_rdy_n), 64'(1));
        rem[0] = 0; bidx[0] = 0; update_drive();
        #3 trn_reset_n = 1'b1;
        @(posedge trn_clk);
        #1;
        step();
        chk("arst_idle", 64'(grant), 64'(0));

        // non-SOF valid beat while idle is a protocol error
        rem[1] = 1; len[1] = 3; bidx[1] = 1; update_drive();
        step();
        chk("nonsof_perr", 64'(proto_err), 64'(1));
        chk("nonsof_nogrant", 64'(grant), 64'(0));
        rem[1] = 0; bidx[1] = 0; update_drive();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
